// File: rtl/port_in8_sync_if.sv
// CPU-side read bus of the input-port block: the address and read strobe
// come from the CPU, and the read data and change interrupt go back to it.
interface port_in8_sync_if;
    logic [7:0] address;
    logic       read;
    logic [7:0] data_out;
    logic       change_irq;

    modport master (
        output address,
        output read,
        input  data_out,
        input  change_irq
    );

    modport slave (
        input  address,
        input  read,
        output data_out,
        output change_irq
    );
endinterface

// File: rtl/port_in8_sync.sv
// Memory-mapped read side of the CPU I/O space.
// - 16 asynchronous 8-bit inputs pass through 2-flop synchronizers into port_val.
// - Ports are readable at F0..FF.
// - Per-port change flags are readable at DE (ports 7..0) and DF (ports 15..8),
//   and reading them clears them.
// - change_irq is high while any change flag is set.
// Optional build macro PORT_IN_DEBOUNCE_EN: a new synchronized value is accepted
// only after it has been stable for DEBOUNCE_CYCLES cycles.
module port_in8_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    port_in8_sync_if.slave  bus,
    input  logic [7:0]      port_in_00,
    input  logic [7:0]      port_in_01,
    input  logic [7:0]      port_in_02,
    input  logic [7:0]      port_in_03,
    input  logic [7:0]      port_in_04,
    input  logic [7:0]      port_in_05,
    input  logic [7:0]      port_in_06,
    input  logic [7:0]      port_in_07,
    input  logic [7:0]      port_in_08,
    input  logic [7:0]      port_in_09,
    input  logic [7:0]      port_in_10,
    input  logic [7:0]      port_in_11,
    input  logic [7:0]      port_in_12,
    input  logic [7:0]      port_in_13,
    input  logic [7:0]      port_in_14,
    input  logic [7:0]      port_in_15
);

    localparam logic [7:0] ADDR_FLAG_LO = 8'hDE;
    localparam logic [7:0] ADDR_FLAG_HI = 8'hDF;

    // Catch an illegal debounce length at elaboration, in either build.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("port_in8_sync: DEBOUNCE_CYCLES must be 1..255");
    end

    logic [7:0]  pins     [16];
    logic [7:0]  sync1    [16];
    logic [7:0]  sync2    [16];
    logic [7:0]  port_val [16];
    logic [7:0]  val_next [16];
    logic [15:0] flag;
    logic [15:0] chg;
    logic [15:0] clr;
    logic [7:0]  rd_data;

    // Gather the individual port buses into an array for indexed handling.
    always_comb begin
        pins[0]  = port_in_00;
        pins[1]  = port_in_01;
        pins[2]  = port_in_02;
        pins[3]  = port_in_03;
        pins[4]  = port_in_04;
        pins[5]  = port_in_05;
        pins[6]  = port_in_06;
        pins[7]  = port_in_07;
        pins[8]  = port_in_08;
        pins[9]  = port_in_09;
        pins[10] = port_in_10;
        pins[11] = port_in_11;
        pins[12] = port_in_12;
        pins[13] = port_in_13;
        pins[14] = port_in_14;
        pins[15] = port_in_15;
    end

`ifdef PORT_IN_DEBOUNCE_EN
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] sync2_d  [16];
    logic [7:0] cnt      [16];
    logic [7:0] cnt_next [16];

    // A value is accepted once it has stayed unchanged, and different from
    // port_val, for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        chg = '0;
        for (int p = 0; p < 16; p++) begin
            val_next[p] = port_val[p];
            cnt_next[p] = cnt[p];
            if (sync2[p] == port_val[p] || sync2[p] != sync2_d[p]) begin
                cnt_next[p] = 8'd0;
            end else if (cnt[p] == CNT_LAST) begin
                val_next[p] = sync2[p];
                cnt_next[p] = 8'd0;
                chg[p]      = 1'b1;
            end else begin
                cnt_next[p] = cnt[p] + 8'd1;
            end
        end
    end

    // Debounce history: previous sync2 value and stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 16; p++) begin
                sync2_d[p] <= 8'h00;
                cnt[p]     <= 8'h00;
            end
        end else begin
            for (int p = 0; p < 16; p++) begin
                sync2_d[p] <= sync2[p];
                cnt[p]     <= cnt_next[p];
            end
        end
    end
`else
    // Without debounce, port_val simply follows the second sync stage.
    always_comb begin
        chg = '0;
        for (int p = 0; p < 16; p++) begin
            val_next[p] = sync2[p];
            chg[p]      = (sync2[p] != port_val[p]);
        end
    end
`endif

    // Two-flop synchronizers followed by the accepted port value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 16; p++) begin
                sync1[p]    <= 8'h00;
                sync2[p]    <= 8'h00;
                port_val[p] <= 8'h00;
            end
        end else begin
            for (int p = 0; p < 16; p++) begin
                sync1[p]    <= pins[p];
                sync2[p]    <= sync1[p];
                port_val[p] <= val_next[p];
            end
        end
    end

    // Address decode for read data and for the flag read-to-clear side effect.
    always_comb begin
        rd_data = 8'h00;
        clr     = '0;
        if (bus.address[7:4] == 4'hF) begin
            rd_data = port_val[bus.address[3:0]];
        end else if (bus.address == ADDR_FLAG_LO) begin
            rd_data = flag[7:0];
            clr     = {8'h00, {8{bus.read}}};
        end else if (bus.address == ADDR_FLAG_HI) begin
            rd_data = flag[15:8];
            clr     = {{8{bus.read}}, 8'h00};
        end
    end

    // Flags: a new change wins over a same-edge clear so no event is lost.
    // data_out loads only on read strobes and otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag         <= '0;
            bus.data_out <= 8'h00;
        end else begin
            flag <= (flag & ~clr) | chg;
            if (bus.read) begin
                bus.data_out <= rd_data;
            end
        end
    end

    // The interrupt is a pure OR of flop outputs, so it cannot glitch on inputs.
    assign bus.change_irq = |flag;

endmodule

// File: tb/tb_port_in8_sync.sv
// Directed bench for port_in8_sync. Inputs change and outputs are sampled on
// the falling clock edge; the design acts on the rising edge.
module tb_port_in8_sync;

`ifdef PORT_IN_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] pin [16];
    logic [7:0] rd;
    int         checks;
    int         failures;

    port_in8_sync_if bus ();

    port_in8_sync #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .port_in_00 (pin[0]),
        .port_in_01 (pin[1]),
        .port_in_02 (pin[2]),
        .port_in_03 (pin[3]),
        .port_in_04 (pin[4]),
        .port_in_05 (pin[5]),
        .port_in_06 (pin[6]),
        .port_in_07 (pin[7]),
        .port_in_08 (pin[8]),
        .port_in_09 (pin[9]),
        .port_in_10 (pin[10]),
        .port_in_11 (pin[11]),
        .port_in_12 (pin[12]),
        .port_in_13 (pin[13]),
        .port_in_14 (pin[14]),
        .port_in_15 (pin[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle read strobe; returns data_out as seen after that edge.
    task automatic do_read(input logic [7:0] addr, output logic [7:0] d);
        bus.address = addr;
        bus.read    = 1'b1;
        @(negedge clk);
        bus.read    = 1'b0;
        d           = bus.data_out;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.address = 8'h00;
        bus.read    = 1'b0;
        for (int i = 0; i < 16; i++) pin[i] = 8'hFF;

        // 1: reset, then ports at FF propagate through the synchronizers
        step(3);
        chk("rst_dout", bus.data_out, 8'h00);
        chk("rst_irq", {7'd0, bus.change_irq}, 8'h00);
        bus.address = 8'hF0;
        bus.read    = 1'b1;
        reset       = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clk);
            chk($sformatf("lat_dout_e%0d", i), bus.data_out, 8'h00);
        end
        chk("lat_irq", {7'd0, bus.change_irq}, 8'h01);
        @(negedge clk);
        chk("lat_dout_ff", bus.data_out, 8'hFF);
        bus.read = 1'b0;
        do_read(8'hDE, rd);  chk("clr_lo_all", rd, 8'hFF);
        do_read(8'hDF, rd);  chk("clr_hi_all", rd, 8'hFF);
        chk("clr_irq0", {7'd0, bus.change_irq}, 8'h00);

        // 2: port read with exact latency, unmapped read, read=0 hold
        pin[5] = 8'hA5;
        step(LAT);
        do_read(8'hF5, rd);  chk("p5_old", rd, 8'hFF);
        do_read(8'hF5, rd);  chk("p5_new", rd, 8'hA5);
        bus.address = 8'hF0;
        step(2);
        chk("hold_dout", bus.data_out, 8'hA5);
        do_read(8'hE0, rd);  chk("unmapped", rd, 8'h00);
        do_read(8'hFF, rd);  chk("p15", rd, 8'hFF);
        do_read(8'hDE, rd);  chk("flag5", rd, 8'h20);
        do_read(8'hDF, rd);  chk("flag_hi0", rd, 8'h00);

        // 3: read-to-clear per byte
        pin[0] = 8'h00;
        pin[9] = 8'h12;
        step(LAT + 1);
        chk("rc_irq1", {7'd0, bus.change_irq}, 8'h01);
        do_read(8'hDE, rd);  chk("rc_lo", rd, 8'h01);
        chk("rc_irq_still", {7'd0, bus.change_irq}, 8'h01);
        do_read(8'hDF, rd);  chk("rc_hi", rd, 8'h02);
        chk("rc_irq0", {7'd0, bus.change_irq}, 8'h00);
        do_read(8'hF9, rd);  chk("p9", rd, 8'h12);

        // 4: flag3 set on the same edge as a DE read-clear
        pin[1] = 8'h33;
        step(LAT + 1);
        pin[3] = 8'h44;
        step(LAT);
        do_read(8'hDE, rd);  chk("col_byte", rd, 8'h02);
        chk("col_irq", {7'd0, bus.change_irq}, 8'h01);
        do_read(8'hDE, rd);  chk("col_next", rd, 8'h08);
        chk("col_irq0", {7'd0, bus.change_irq}, 8'h00);

`ifdef PORT_IN_DEBOUNCE_EN
        // 5: short glitch rejected, long level accepted after 2+4 edges
        pin[2] = 8'h5A;
        step(2);
        pin[2] = 8'hFF;
        step(10);
        do_read(8'hF2, rd);  chk("db_glitch_val", rd, 8'hFF);
        do_read(8'hDE, rd);  chk("db_glitch_flag", rd, 8'h00);
        pin[2] = 8'h5A;
        step(LAT);
        do_read(8'hF2, rd);  chk("db_level_old", rd, 8'hFF);
        do_read(8'hF2, rd);  chk("db_level_new", rd, 8'h5A);
        do_read(8'hDE, rd);  chk("db_flag2", rd, 8'h04);
`endif

        // 6: reset asserted in the middle of a DF read with flags pending
        pin[10] = 8'h77;
        step(LAT + 1);
        chk("mid_irq_pend", {7'd0, bus.change_irq}, 8'h01);
        bus.address = 8'hDF;
        bus.read    = 1'b1;
        #2 reset    = 1'b1;
        #1;
        chk("mid_dout", bus.data_out, 8'h00);
        chk("mid_irq", {7'd0, bus.change_irq}, 8'h00);
        @(negedge clk);
        bus.read = 1'b0;
        reset    = 1'b0;
        do_read(8'hF5, rd);  chk("post_rst_p5", rd, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
